// File: rtl/regfile_wr_ctrl.sv
// rtl/regfile_wr_ctrl.sv - write-port controller for the 32x64 register file
// Round-robin shares the single write port and sequences X0..X30 = 0..30 initialisation.
module regfile_wr_ctrl #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init_start,
  output logic         init_busy,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [4:0]   req0_addr,
  input  logic [N-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [4:0]   req1_addr,
  input  logic [N-1:0] req1_data,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3
);

  typedef enum logic {INIT, RUN} state_t;

  state_t     state;
  logic [4:0] cnt;
  logic       lg;
  logic       fire0;
  logic       fire1;

  assign init_busy = (state == INIT);

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == RUN && !init_start) begin
      if (req0_valid && req1_valid) begin
        if (lg) req0_ready = 1'b1;
        else    req1_ready = 1'b1;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign fire0 = req0_valid & req0_ready;
  assign fire1 = req1_valid & req1_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt   <= 5'd0;
      lg    <= 1'b1;
      we3   <= 1'b0;
      wa3   <= 5'd0;
      wd3   <= '0;
    end else begin
      case (state)
        INIT: begin
          we3 <= 1'b1;
          wa3 <= cnt;
          wd3 <= N'(cnt);
          cnt <= cnt + 5'd1;
          if (cnt == 5'd30) state <= RUN;
        end
        RUN: begin
          if (init_start) begin
            state <= INIT;
            cnt   <= 5'd0;
            we3   <= 1'b0;
          end else if (fire0) begin
            // XZR writes are consumed but never reach the register file.
            we3 <= (req0_addr != 5'd31);
            wa3 <= req0_addr;
            wd3 <= req0_data;
            lg  <= 1'b0;
          end else if (fire1) begin
            we3 <= (req1_addr != 5'd31);
            wa3 <= req1_addr;
            wd3 <= req1_data;
            lg  <= 1'b1;
          end else begin
            we3 <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
